hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Sequences the IF_ID / ID_EX / EX_MEM pipeline registers and the PC.
//  Detects load-use hazards (bubble insert), taken branch/jump resolved in MEM (3-stage flush),
//  and multi-cycle data-memory access (whole-pipe freeze via req/ack).
//  Drives per-stage enable/flush; sticky error on memory timeout.
// PARAMETERS
//  REG_ADDR_W   5   register-number width
//  MEM_TIMEOUT  15  max wait cycles for mem_ack before ERROR (>=1)
//  CNT_W        16  width of performance counters
// PORTS
//  clk               in   1           rising-edge clock; only clock in the block
//  rst_n             in   1           synchronous reset, active low
//  rs_ID             in   REG_ADDR_W  source reg A of instr in ID
//  rt_ID             in   REG_ADDR_W  source reg B of instr in ID
//  rt_used_ID        in   1           instr in ID reads rt
//  MemRead_EX        in   1           instr in EX is a load
//  Write_register_EX in   REG_ADDR_W  destination reg of instr in EX
//  Branch_MEM        in   1           branch in MEM
//  Zero_MEM          in   1           ALU zero for branch in MEM
//  Jump_MEM          in   1           jump in MEM
//  MemRead_MEM       in   1           load in MEM
//  MemWrite_MEM      in   1           store in MEM
//  mem_ack           in   1           data memory done (same-cycle or later)
//  pc_en             out  1           PC update enable
//  pc_sel_target     out  1           PC loads PC_next_MEM (branch/jump target)
//  if_id_en / id_ex_en / ex_mem_en  out 1 each   stage register load enable
//  if_id_flush / id_ex_flush / ex_mem_flush  out 1 each   load bubble (all controls 0)
//  mem_err           out  1           sticky memory-timeout flag
//  stall_cnt / flush_cnt / memwait_cnt  out CNT_W each   perf counters
// BEHAVIOUR
//  State: RUN, MEM_WAIT, ERROR; wait_cnt (clog2(MEM_TIMEOUT+1) bits). Outputs combinational from state+inputs.
//  rst_n=0 at posedge: state<=RUN, wait_cnt<=0, counters<=0, mem_err<=0. While rst_n=0, outputs
//   forced: all *_en=0, all *_flush=1, pc_sel_target=0, mem_err=0.
//  mem_busy = (MemRead_MEM|MemWrite_MEM) & ~mem_ack; taken = (Branch_MEM&Zero_MEM)|Jump_MEM;
//  lu = MemRead_EX & (Write_register_EX!=0) & (Write_register_EX==rs_ID | (rt_used_ID & Write_register_EX==rt_ID)).
//  Default (RUN, none active): all *_en=1, all *_flush=0, pc_sel_target=0.
//  Priority in RUN: mem_busy > taken > lu.
//   mem_busy: all *_en=0, no flush; next MEM_WAIT, wait_cnt<=1.
//   taken: pc_en=1, pc_sel_target=1, if_id/id_ex/ex_mem_flush=1; lu ignored. Next RUN.
//   lu: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Exactly one bubble per load (EX holds bubble next cycle).
//  MEM_WAIT: mem_ack=0 -> all *_en=0; if wait_cnt==MEM_TIMEOUT next ERROR else wait_cnt+1.
//   mem_ack=1 -> outputs exactly as RUN with mem_busy=0 (taken/lu evaluated); next RUN, wait_cnt<=0.
//   Ack in the timeout cycle wins over ERROR.
//  ERROR: all *_en=0, no flush, mem_err=1; exit only via rst_n=0.
//  Flushes apply only when the stage register is enabled; flush has priority over hold at the register.
//  Reset mid-MEM_WAIT: abandons access, RUN next cycle, no error.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt +1 per lu cycle, flush_cnt +1 per taken cycle,
//   memwait_cnt +1 per cycle with all *_en=0 due to mem (RUN mem_busy or MEM_WAIT no ack);
//   saturating at 2^CNT_W-1; cleared by reset.
//  Not defined: counters not built; the three outputs tied to 0.
// TESTING
//  1 lw r5 in EX (MemRead_EX=1,Write_register_EX=5), rs_ID=5 -> 1 cycle pc_en=0,if_id_en=0,id_ex_flush=1; next cycle all en=1.
//  2 Write_register_EX=0, rs_ID=0, MemRead_EX=1 -> no stall; rt_ID=5, rt_used_ID=0, Write_register_EX=5 -> no stall.
//  3 Branch_MEM=1,Zero_MEM=1 with lu also true -> pc_sel_target=1, 3 flushes=1, pc_en=1, no stall.
//  4 MemRead_MEM=1, mem_ack low 3 cycles then high -> 3 cycles all en=0, 4th cycle all en=1, state RUN.
//  5 mem_ack never asserted, MEM_TIMEOUT=15 -> mem_err=1 after 16 frozen cycles; stays until rst_n=0.
//  6 rst_n=0 during MEM_WAIT -> flushes=1,en=0; after release RUN, mem_err=0; with HAZARD_PERF_CNT_EN, counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall sequencer: load-use bubble, MEM-resolved branch flush, data-memory freeze with timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
   parameter int REG_ADDR_W  = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REG_ADDR_W-1:0] i_rs_ID,
   input  logic [REG_ADDR_W-1:0] i_rt_ID,
   input  logic                  i_rt_used_ID,
   input  logic                  i_MemRead_EX,
   input  logic [REG_ADDR_W-1:0] i_Write_register_EX,
   input  logic                  i_Branch_MEM,
   input  logic                  i_Zero_MEM,
   input  logic                  i_Jump_MEM,
   input  logic                  i_MemRead_MEM,
   input  logic                  i_MemWrite_MEM,
   input  logic                  i_mem_ack,
   output logic                  o_pc_en,
   output logic                  o_pc_sel_target,
   output logic                  o_if_id_en,
   output logic                  o_id_ex_en,
   output logic                  o_ex_mem_en,
   output logic                  o_if_id_flush,
   output logic                  o_id_ex_flush,
   output logic                  o_ex_mem_flush,
   output logic                  o_mem_err,
   output logic [CNT_W-1:0]      o_stall_cnt,
   output logic [CNT_W-1:0]      o_flush_cnt,
   output logic [CNT_W-1:0]      o_memwait_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

   state_t            r_state, w_state_nxt;
   logic [WC_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
   logic              r_mem_err;
   logic              w_mem_busy, w_taken, w_lu;
   logic              w_eval, w_freeze;

   assign w_mem_busy = (i_MemRead_MEM | i_MemWrite_MEM) & ~i_mem_ack;
   assign w_taken    = (i_Branch_MEM & i_Zero_MEM) | i_Jump_MEM;
   assign w_lu       = i_MemRead_EX & (i_Write_register_EX != '0) &
                       ((i_Write_register_EX == i_rs_ID) |
                        (i_rt_used_ID & (i_Write_register_EX == i_rt_ID)));

   // w_eval: hazards are honoured this cycle; w_freeze: whole pipe held
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_eval         = 1'b0;
      w_freeze       = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_mem_busy) begin
               w_freeze       = 1'b1;
               w_state_nxt    = S_MEM_WAIT;
               w_wait_cnt_nxt = WC_W'(1);
            end else begin
               w_eval = 1'b1;
            end
         end
         S_MEM_WAIT: begin
            if (i_mem_ack) begin
               w_eval         = 1'b1;
               w_state_nxt    = S_RUN;
               w_wait_cnt_nxt = '0;
            end else begin
               w_freeze = 1'b1;
               if (r_wait_cnt == WC_W'(MEM_TIMEOUT)) w_state_nxt = S_ERROR;
               else                                  w_wait_cnt_nxt = r_wait_cnt + WC_W'(1);
            end
         end
         S_ERROR: w_freeze = 1'b1;
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      o_pc_en         = 1'b1;
      o_pc_sel_target = 1'b0;
      o_if_id_en      = 1'b1;
      o_id_ex_en      = 1'b1;
      o_ex_mem_en     = 1'b1;
      o_if_id_flush   = 1'b0;
      o_id_ex_flush   = 1'b0;
      o_ex_mem_flush  = 1'b0;
      o_mem_err       = r_mem_err;
      if (w_freeze) begin
         o_pc_en     = 1'b0;
         o_if_id_en  = 1'b0;
         o_id_ex_en  = 1'b0;
         o_ex_mem_en = 1'b0;
      end else if (w_eval && w_taken) begin
         o_pc_sel_target = 1'b1;
         o_if_id_flush   = 1'b1;
         o_id_ex_flush   = 1'b1;
         o_ex_mem_flush  = 1'b1;
      end else if (w_eval && w_lu) begin
         o_pc_en       = 1'b0;
         o_if_id_en    = 1'b0;
         o_id_ex_flush = 1'b1;
      end
      if (!i_rst_n) begin
         o_pc_en         = 1'b0;
         o_pc_sel_target = 1'b0;
         o_if_id_en      = 1'b0;
         o_id_ex_en      = 1'b0;
         o_ex_mem_en     = 1'b0;
         o_if_id_flush   = 1'b1;
         o_id_ex_flush   = 1'b1;
         o_ex_mem_flush  = 1'b1;
         o_mem_err       = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         r_mem_err  <= r_mem_err | (w_state_nxt == S_ERROR);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic             w_inc_stall, w_inc_flush, w_inc_mw;
   logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_memwait_cnt;

   assign w_inc_stall = w_eval & ~w_taken & w_lu;
   assign w_inc_flush = w_eval & w_taken;
   assign w_inc_mw    = w_freeze & (r_state != S_ERROR);

   // Saturating: a counter parks at all-ones rather than wrapping
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_stall_cnt   <= '0;
         r_flush_cnt   <= '0;
         r_memwait_cnt <= '0;
      end else begin
         if (w_inc_stall && (r_stall_cnt   != '1)) r_stall_cnt   <= r_stall_cnt   + CNT_W'(1);
         if (w_inc_flush && (r_flush_cnt   != '1)) r_flush_cnt   <= r_flush_cnt   + CNT_W'(1);
         if (w_inc_mw    && (r_memwait_cnt != '1)) r_memwait_cnt <= r_memwait_cnt + CNT_W'(1);
      end
   end

   assign o_stall_cnt   = r_stall_cnt;
   assign o_flush_cnt   = r_flush_cnt;
   assign o_memwait_cnt = r_memwait_cnt;
`else
   assign o_stall_cnt   = '0;
   assign o_flush_cnt   = '0;
   assign o_memwait_cnt = '0;
`endif

endmodule
